fg_detection_pipe: RTL and testbench
====================================

// Module: fg_detection_pipe
// PURPOSE
//   Parametrised, flow-controlled successor of the MoG foreground detector. It sits after the
//   Gaussian parameter-update stage and before the binary-mask writer. Per pixel it tests
//   NUM_GAUSS Gaussians for a background match and forwards the updated parameters with is_fg.
//   It also counts foreground pixels per frame using SOF/EOF sideband.
// PARAMETERS
//   NUM_GAUSS  3   Gaussians per pixel (>=1)
//   DATA_W     32  width of each mean/sd/weight/abs_diff field
//   FG_W       16  width of FG_THRESHOLD (FG_W <= DATA_W)
//   CNT_W      20  width of the per-frame foreground counter
// PORTS
//   clk             in   1                  clock, all state on rising edge
//   rst_n           in   1                  async active-low reset
//   in_valid        in   1                  input beat valid
//   in_ready        out  1                  input beat accepted when in_valid&in_ready
//   in_sof          in   1                  beat is first pixel of frame
//   in_eof          in   1                  beat is last pixel of frame
//   mean_in         in   NUM_GAUSS*DATA_W   updated means, Gaussian k at [k*DATA_W +: DATA_W]
//   sd_in           in   NUM_GAUSS*DATA_W   updated std deviations, same packing
//   w_in            in   NUM_GAUSS*DATA_W   updated weights, same packing
//   abs_diff_in     in   NUM_GAUSS*DATA_W   |pixel-mean_k|, same packing
//   FG_THRESHOLD    in   FG_W               weight threshold MSBs, quasi-static
//   MATCH_THRESHOLD in   4                  match factor in half-sigma units, quasi-static
//   out_valid       out  1                  output beat valid
//   out_ready       in   1                  downstream accepts when out_valid&out_ready
//   mean_out/sd_out/w_out out NUM_GAUSS*DATA_W  parameters delayed in step with is_fg
//   is_fg           out  1                  1 = foreground pixel
//   match_any       out  1                  1 = at least one Gaussian matched
//   match_idx       out  $clog2(NUM_GAUSS)  lowest matching k (0 if none; min width 1)
//   out_sof/out_eof out  1                  sideband delayed with the beat
//   frame_fg_count  out  CNT_W              FG pixel count of the last completed frame
//   frame_done      out  1                  1-cycle pulse when frame_fg_count updates
// BEHAVIOUR
//   - Reset: out_valid, is_fg, match_any, match_idx, out_sof, out_eof, frame_fg_count,
//     frame_done, internal counter and all stage valids = 0. Data outputs = 0.
//   - Pipeline: 2 stages, each with a valid bit. Global advance en = !out_valid | out_ready.
//     in_ready = en, combinational. A stall freezes both stages. No beat is lost or
//     duplicated. Latency is 2 accepted cycles with no stall.
//   - Stage 1 registers thr_k = (sd_k * MATCH_THRESHOLD) >> 1 at DATA_W+4 bits (no
//     truncation), plus all inputs and sideband.
//   - Stage 2 computes m_k = (abs_diff_k <= thr_k) &&
//     (w_k >= {FG_THRESHOLD, {DATA_W-FG_W{1'b1}}}), all comparisons unsigned.
//     Registered results: match_any = |m; is_fg = ~match_any; match_idx = lowest k with m_k.
//   - Bubbles (stage valid = 0) advance while en = 1. Output data does not change while
//     out_valid & !out_ready.
//   - Frame counter runs on output handshake (out_valid&out_ready), with cnt = running count:
//       cnt_next = (out_sof ? 0 : cnt) + is_fg, saturating at 2^CNT_W-1.
//       If out_eof: frame_fg_count <= cnt_next; frame_done = 1 next cycle; cnt <= 0.
//   - SOF and EOF on the same beat form a 1-pixel frame: count = is_fg.
//   - SOF without a prior EOF discards the partial count.
//   - EOF with no SOF since reset counts from reset.
//   - Async reset mid-frame or mid-stall clears everything. The first accepted beat after
//     reset starts a new count.
// TESTING
//   1 NUM_GAUSS=3, MATCH_THRESHOLD=5, sd1=8 (thr=20), abs_diff1=20, w1=32'h8000_0000,
//     FG_THRESHOLD=16'h7FFF -> is_fg=0, match_idx=0, 2 cycles after accept;
//     abs_diff1=21, others unmatched -> is_fg=1, match_any=0.
//   2 Weight boundary: w2=32'h7FFF_FFFF vs FG_THRESHOLD 16'h7FFF -> match;
//     w2=32'h7FFF_FFFE -> no match.
//   3 Backpressure: stream 10 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0,
//     outputs stable, all 10 beats appear once, in order, params bit-exact.
//   4 Frame: SOF..EOF over 8 pixels with 3 FG -> frame_fg_count=3, frame_done pulse once;
//     SOF+EOF single-pixel FG frame -> count=1.
//   5 Overflow/width: sd=32'hFFFF_FFFF, MATCH_THRESHOLD=15 -> no truncation, abs_diff=
//     32'hFFFF_FFFF matches; CNT_W=2, 5 FG pixels -> count saturates at 3.
//   6 Assert rst_n low during stall with valid data -> outputs zero immediately; restart clean.

Source files
------------

// File: rtl/fg_detection_pipe.sv
// fg_detection_pipe: two-stage flow-controlled MoG background-match test with
// per-frame foreground pixel counting driven by SOF/EOF sideband.
module fg_detection_pipe #(
   parameter int unsigned NUM_GAUSS = 3,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned FG_W      = 16,
   parameter int unsigned CNT_W     = 20,
   localparam int unsigned IDX_W    = (NUM_GAUSS > 1) ? $clog2(NUM_GAUSS) : 1,
   localparam int unsigned VEC_W    = NUM_GAUSS * DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sof,
   input  logic              in_eof,
   input  logic [VEC_W-1:0]  mean_in,
   input  logic [VEC_W-1:0]  sd_in,
   input  logic [VEC_W-1:0]  w_in,
   input  logic [VEC_W-1:0]  abs_diff_in,
   input  logic [FG_W-1:0]   FG_THRESHOLD,
   input  logic [3:0]        MATCH_THRESHOLD,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VEC_W-1:0]  mean_out,
   output logic [VEC_W-1:0]  sd_out,
   output logic [VEC_W-1:0]  w_out,
   output logic              is_fg,
   output logic              match_any,
   output logic [IDX_W-1:0]  match_idx,
   output logic              out_sof,
   output logic              out_eof,
   output logic [CNT_W-1:0]  frame_fg_count,
   output logic              frame_done
);

   localparam int unsigned THR_W = DATA_W + 4;

   logic                 w_en;
   logic                 w_out_hs;
   logic                 r_s1_valid;
   logic                 r_s1_sof;
   logic                 r_s1_eof;
   logic [VEC_W-1:0]     r_s1_mean;
   logic [VEC_W-1:0]     r_s1_sd;
   logic [VEC_W-1:0]     r_s1_w;
   logic [VEC_W-1:0]     r_s1_ad;
   logic [THR_W-1:0]     r_s1_thr [NUM_GAUSS];
   logic [THR_W-1:0]     w_thr    [NUM_GAUSS];
   logic [DATA_W-1:0]    w_wthr;
   logic [NUM_GAUSS-1:0] w_match;
   logic                 w_any;
   logic [IDX_W-1:0]     w_idx;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_base;
   logic [CNT_W-1:0]     w_cnt_next;

   // Single global enable: the output register is the only place a stall can originate.
   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;
   assign w_out_hs = out_valid && out_ready;

   always_comb begin
      for (int unsigned k = 0; k < NUM_GAUSS; k++) begin
         w_thr[k] = (THR_W'(sd_in[k*DATA_W +: DATA_W]) * THR_W'(MATCH_THRESHOLD)) >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sof   <= 1'b0;
         r_s1_eof   <= 1'b0;
         r_s1_mean  <= '0;
         r_s1_sd    <= '0;
         r_s1_w     <= '0;
         r_s1_ad    <= '0;
         for (int unsigned k = 0; k < NUM_GAUSS; k++) begin
            r_s1_thr[k] <= '0;
         end
      end else if (w_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sof  <= in_sof;
            r_s1_eof  <= in_eof;
            r_s1_mean <= mean_in;
            r_s1_sd   <= sd_in;
            r_s1_w    <= w_in;
            r_s1_ad   <= abs_diff_in;
            for (int unsigned k = 0; k < NUM_GAUSS; k++) begin
               r_s1_thr[k] <= w_thr[k];
            end
         end
      end
   end

   // Weight threshold is FG_THRESHOLD in the MSBs with all lower bits set.
   always_comb begin
      w_wthr = '1;
      w_wthr[DATA_W-1 -: FG_W] = FG_THRESHOLD;
      w_match = '0;
      for (int unsigned k = 0; k < NUM_GAUSS; k++) begin
         w_match[k] = (THR_W'(r_s1_ad[k*DATA_W +: DATA_W]) <= r_s1_thr[k]) &&
                      (r_s1_w[k*DATA_W +: DATA_W] >= w_wthr);
      end
      w_any = |w_match;
      w_idx = '0;
      for (int unsigned k = NUM_GAUSS; k > 0; k--) begin
         if (w_match[k-1]) begin
            w_idx = IDX_W'(k - 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         mean_out  <= '0;
         sd_out    <= '0;
         w_out     <= '0;
         is_fg     <= 1'b0;
         match_any <= 1'b0;
         match_idx <= '0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (w_en) begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            mean_out  <= r_s1_mean;
            sd_out    <= r_s1_sd;
            w_out     <= r_s1_w;
            is_fg     <= !w_any;
            match_any <= w_any;
            match_idx <= w_idx;
            out_sof   <= r_s1_sof;
            out_eof   <= r_s1_eof;
         end
      end
   end

   always_comb begin
      w_cnt_base = out_sof ? '0 : r_cnt;
      w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(is_fg);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt          <= '0;
         frame_fg_count <= '0;
         frame_done     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (w_out_hs) begin
            if (out_eof) begin
               frame_fg_count <= w_cnt_next;
               frame_done     <= 1'b1;
               r_cnt          <= '0;
            end else begin
               r_cnt <= w_cnt_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_fg_detection_pipe.sv
// Directed bench for fg_detection_pipe: a default instance plus a CNT_W=2 instance
// sharing stimulus, with an in-order expected-beat queue checked on output handshakes.
module tb_fg_detection_pipe;

   localparam int unsigned NG = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned VW = NG * DW;
   localparam logic [31:0] WHI = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_sof, in_eof, out_ready;
   logic [VW-1:0] mean_in, sd_in, w_in, abs_diff_in;
   logic [15:0]   FG_THRESHOLD;
   logic [3:0]    MATCH_THRESHOLD;

   logic          in_ready, out_valid, is_fg, match_any, out_sof, out_eof, frame_done;
   logic [VW-1:0] mean_out, sd_out, w_out;
   logic [1:0]    match_idx;
   logic [19:0]   frame_fg_count;

   logic          s_in_ready, s_out_valid, s_is_fg, s_match_any, s_out_sof, s_out_eof, s_frame_done;
   logic [VW-1:0] s_mean_out, s_sd_out, s_w_out;
   logic [1:0]    s_match_idx;
   logic [1:0]    s_frame_fg_count;

   always #5 clk = ~clk;

   fg_detection_pipe #(.NUM_GAUSS(NG), .DATA_W(DW), .FG_W(16), .CNT_W(20)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sof(in_sof), .in_eof(in_eof), .mean_in(mean_in), .sd_in(sd_in), .w_in(w_in),
      .abs_diff_in(abs_diff_in), .FG_THRESHOLD(FG_THRESHOLD), .MATCH_THRESHOLD(MATCH_THRESHOLD),
      .out_valid(out_valid), .out_ready(out_ready), .mean_out(mean_out), .sd_out(sd_out),
      .w_out(w_out), .is_fg(is_fg), .match_any(match_any), .match_idx(match_idx),
      .out_sof(out_sof), .out_eof(out_eof), .frame_fg_count(frame_fg_count),
      .frame_done(frame_done)
   );

   fg_detection_pipe #(.NUM_GAUSS(NG), .DATA_W(DW), .FG_W(16), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_sof(in_sof), .in_eof(in_eof), .mean_in(mean_in), .sd_in(sd_in), .w_in(w_in),
      .abs_diff_in(abs_diff_in), .FG_THRESHOLD(FG_THRESHOLD), .MATCH_THRESHOLD(MATCH_THRESHOLD),
      .out_valid(s_out_valid), .out_ready(out_ready), .mean_out(s_mean_out), .sd_out(s_sd_out),
      .w_out(s_w_out), .is_fg(s_is_fg), .match_any(s_match_any), .match_idx(s_match_idx),
      .out_sof(s_out_sof), .out_eof(s_out_eof), .frame_fg_count(s_frame_fg_count),
      .frame_done(s_frame_done)
   );

   typedef struct {
      logic          sof;
      logic          eof;
      logic [VW-1:0] mean;
      logic [VW-1:0] sd;
      logic [VW-1:0] w;
      logic [VW-1:0] ad;
      logic          efg;
      logic          eany;
      logic [1:0]    eidx;
   } beat_t;

   beat_t       exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned done_cnt = 0;
   int unsigned s_done_cnt = 0;

   task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t mkb(input logic [31:0] id, input logic sof, input logic eof,
                                 input logic [31:0] s0, input logic [31:0] a0, input logic [31:0] w0,
                                 input logic [31:0] s1, input logic [31:0] a1, input logic [31:0] w1,
                                 input logic [31:0] s2, input logic [31:0] a2, input logic [31:0] w2,
                                 input logic efg, input logic eany, input logic [1:0] eidx);
      beat_t b;
      b.sof  = sof;
      b.eof  = eof;
      b.mean = {id + 32'd2, id + 32'd1, id};
      b.sd   = {s2, s1, s0};
      b.ad   = {a2, a1, a0};
      b.w    = {w2, w1, w0};
      b.efg  = efg;
      b.eany = eany;
      b.eidx = eidx;
      return b;
   endfunction

   function automatic beat_t fgpix(input logic [31:0] id, input logic sof, input logic eof);
      return mkb(id, sof, eof, 8, 100, WHI, 8, 100, WHI, 8, 100, WHI, 1'b1, 1'b0, 2'd0);
   endfunction

   function automatic beat_t bgpix(input logic [31:0] id, input logic sof, input logic eof);
      return mkb(id, sof, eof, 8, 20, WHI, 8, 100, WHI, 8, 100, WHI, 1'b0, 1'b1, 2'd0);
   endfunction

   // Output monitor: stall stability and in-order beat comparison, sampled on negedge.
   logic [319:0] snap;
   logic         stalled = 1'b0;
   always @(negedge clk) begin
      beat_t b;
      if (out_valid && !out_ready) begin
         chk("stall_in_ready", in_ready, 1'b0);
         if (stalled)
            chk("stall_hold", {mean_out, sd_out, w_out, is_fg, match_any, match_idx, out_sof, out_eof}, snap);
         snap    = {mean_out, sd_out, w_out, is_fg, match_any, match_idx, out_sof, out_eof};
         stalled = 1'b1;
      end else begin
         stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
         chk("beat_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("mean_out", mean_out, b.mean);
            chk("sd_out", sd_out, b.sd);
            chk("w_out", w_out, b.w);
            chk("is_fg", is_fg, b.efg);
            chk("match_any", match_any, b.eany);
            chk("match_idx", match_idx, b.eidx);
            chk("sideband", {out_sof, out_eof}, {b.sof, b.eof});
            chk("sat_beat", {s_out_valid, s_is_fg, s_match_any, s_match_idx, s_out_sof, s_out_eof},
                {1'b1, b.efg, b.eany, b.eidx, b.sof, b.eof});
            chk("sat_params", {s_mean_out, s_sd_out, s_w_out}, {b.mean, b.sd, b.w});
         end
      end
      if (frame_done) done_cnt++;
      if (s_frame_done) s_done_cnt++;
   end

   task automatic send(input beat_t b);
      int unsigned n = 0;
      in_valid    = 1'b1;
      in_sof      = b.sof;
      in_eof      = b.eof;
      mean_in     = b.mean;
      sd_in       = b.sd;
      w_in        = b.w;
      abs_diff_in = b.ad;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept", in_ready, 1'b1);
      chk("sat_accept", s_in_ready, 1'b1);
      if (in_ready) exp_q.push_back(b);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned d0;
      int unsigned sd0;
      rst_n           = 1'b0;
      in_valid        = 1'b0;
      in_sof          = 1'b0;
      in_eof          = 1'b0;
      out_ready       = 1'b1;
      mean_in         = '0;
      sd_in           = '0;
      w_in            = '0;
      abs_diff_in     = '0;
      FG_THRESHOLD    = 16'h7FFF;
      MATCH_THRESHOLD = 4'd5;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_flags", {is_fg, match_any, match_idx, out_sof, out_eof, frame_done}, '0);
      chk("rst_count", frame_fg_count, '0);
      chk("rst_data", {mean_out, sd_out, w_out}, '0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      // Match threshold and weight boundaries, plus two-stage latency.
      send(bgpix(32'hA000_0000, 1'b0, 1'b0));
      chk("lat_stage1", out_valid, 1'b0);
      @(negedge clk);
      chk("lat_stage2", out_valid, 1'b1);
      send(mkb(32'hA000_0010, 0, 0, 8, 21, WHI, 8, 21, WHI, 8, 21, WHI, 1'b1, 1'b0, 2'd0));
      send(mkb(32'hA000_0020, 0, 0, 8, 100, WHI, 8, 0, 32'h7FFF_FFFF, 8, 100, WHI, 1'b0, 1'b1, 2'd1));
      send(mkb(32'hA000_0030, 0, 0, 8, 100, WHI, 8, 0, 32'h7FFF_FFFE, 8, 100, WHI, 1'b1, 1'b0, 2'd0));
      send(mkb(32'hA000_0040, 0, 0, 8, 100, WHI, 8, 100, WHI, 8, 20, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'd2));
      send(mkb(32'hA000_0050, 0, 0, 8, 100, WHI, 8, 3, 32'h9000_0000, 8, 3, 32'h9000_0000, 1'b0, 1'b1, 2'd1));
      drain();

      // Wide threshold: 15*(2^32-1)>>1 = 0x7_FFFF_FFF8 must not truncate.
      MATCH_THRESHOLD = 4'd15;
      send(mkb(32'hA000_0060, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, WHI, 8, 100, WHI, 8, 100, WHI, 1'b0, 1'b1, 2'd0));
      send(mkb(32'hA000_0070, 0, 0, 8, 61, WHI, 8, 60, WHI, 8, 100, WHI, 1'b0, 1'b1, 2'd1));
      drain();
      MATCH_THRESHOLD = 4'd5;

      // Backpressure: 5-cycle stall in the middle of a 10-beat stream.
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               if (i % 3 == 0) send(bgpix(32'hB000_0000 + 32'(i * 16), 1'b0, 1'b0));
               else            send(fgpix(32'hB000_0000 + 32'(i * 16), 1'b0, 1'b0));
            end
         end
         begin
            repeat (4) @(posedge clk);
            #2 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2 out_ready = 1'b1;
         end
      join
      drain();

      // Frames: a partial frame is discarded by the next SOF.
      d0  = done_cnt;
      sd0 = s_done_cnt;
      send(fgpix(32'hC000_0000, 1'b1, 1'b0));
      send(fgpix(32'hC000_0010, 1'b0, 1'b0));
      for (int i = 0; i < 8; i++) begin
         if (i == 1 || i == 4 || i == 7)
            send(fgpix(32'hC000_0100 + 32'(i * 16), i == 0, i == 7));
         else
            send(bgpix(32'hC000_0100 + 32'(i * 16), i == 0, i == 7));
      end
      drain();
      chk("frame8_count", frame_fg_count, 20'd3);
      chk("frame8_done_once", done_cnt - d0, 1);
      chk("sat_frame8_count", s_frame_fg_count, 2'd3);
      chk("sat_frame8_done", s_done_cnt - sd0, 1);

      d0 = done_cnt;
      send(fgpix(32'hC000_0200, 1'b1, 1'b1));
      drain();
      chk("frame1_count", frame_fg_count, 20'd1);
      chk("frame1_done_once", done_cnt - d0, 1);
      chk("sat_frame1_count", s_frame_fg_count, 2'd1);

      for (int i = 0; i < 5; i++) send(fgpix(32'hC000_0300 + 32'(i * 16), i == 0, i == 4));
      drain();
      chk("frame5_count", frame_fg_count, 20'd5);
      chk("sat_frame5_saturated", s_frame_fg_count, 2'd3);

      // Async reset while stalled with valid data, after a partial frame.
      send(fgpix(32'hD000_0000, 1'b1, 1'b0));
      drain();
      out_ready = 1'b0;
      send(bgpix(32'hD000_0010, 1'b0, 1'b0));
      send(fgpix(32'hD000_0020, 1'b0, 1'b0));
      @(negedge clk);
      chk("stall_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_flags", {is_fg, match_any, match_idx, out_sof, out_eof, frame_done}, '0);
      chk("arst_data", {mean_out, sd_out, w_out}, '0);
      chk("arst_count", {frame_fg_count, s_frame_fg_count}, '0);
      chk("arst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      d0 = done_cnt;
      send(fgpix(32'hD000_0100, 1'b0, 1'b0));
      send(fgpix(32'hD000_0110, 1'b0, 1'b1));
      drain();
      chk("post_rst_count", frame_fg_count, 20'd2);
      chk("post_rst_done_once", done_cnt - d0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
